// File: rtl/rpe_pkg.sv
// rtl/rpe_pkg.sv - shared types, constants and helpers for the random PE traffic generator
package rpe_pkg;

    // Destination pattern selected at elaboration time
    typedef enum logic {
        PAT_RANDOM    = 1'b0,
        PAT_TRANSPOSE = 1'b1
    } pat_e;

    // Galois LFSR feedback mask (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Total flit width: dest x, dest y, payload
    function automatic int tw_width(input int xs, input int ys, input int dw);
        return xs + ys + dw;
    endfunction

    // One right-shifting Galois LFSR step
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/random_pe_top_if.sv
// rtl/random_pe_top_if.sv - NoC injection/delivery bundle between the PE array and the mesh
interface random_pe_top_if #(
    parameter int N  = 100,
    parameter int TW = 264
);
    logic [N-1:0]    r_valid_pe;
    logic [TW*N-1:0] r_data_pe;
    logic [N-1:0]    r_ready_pe;
    logic [N-1:0]    w_valid_pe;
    logic [TW*N-1:0] w_data_pe;

    // PE array side
    modport master (
        output r_valid_pe,
        output r_data_pe,
        input  r_ready_pe,
        input  w_valid_pe,
        input  w_data_pe
    );

    // NoC side
    modport slave (
        input  r_valid_pe,
        input  r_data_pe,
        output r_ready_pe,
        output w_valid_pe,
        output w_data_pe
    );
endinterface

// File: rtl/random_pe_top_random_pe.sv
// rtl/random_pe_top_random_pe.sv - one traffic-generating/counting PE (macro RPE_DEST_CHECK_EN)
module random_pe
    import rpe_pkg::*;
#(
    parameter int   X          = 10,
    parameter int   Y          = 10,
    parameter int   data_width = 256,
    parameter int   x_size     = 4,
    parameter int   y_size     = 4,
    parameter int   numPackets = 1000,
    parameter int   rate       = 2,
    parameter pat_e PAT_SEL    = PAT_RANDOM,
    parameter int   IDX        = 0,
    localparam int  TW         = tw_width(x_size, y_size, data_width)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          enable_i,
    output logic          r_valid_o,
    output logic [TW-1:0] r_data_o,
    input  logic          r_ready_i,
    input  logic          w_valid_i,
    input  logic [TW-1:0] w_data_i,
    output logic [31:0]   recv_count_o,
    output logic          fin_o
);

    localparam int MY_X = IDX % X;
    localparam int MY_Y = IDX / X;
    localparam int SW   = (rate > 1) ? $clog2(rate) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(rate - 1);

`ifdef RPE_DEST_CHECK_EN
    localparam bit DEST_CHECK = 1'b1;
`else
    localparam bit DEST_CHECK = 1'b0;
`endif

    logic [SW-1:0]         slot_q, slot_d;
    logic                  valid_q;
    logic [TW-1:0]         data_q, pkt_d;
    logic [31:0]           sent_q;
    logic [31:0]           rcv_q;
    logic [15:0]           lfsr_q;
    logic [x_size-1:0]     dx_d;
    logic [y_size-1:0]     dy_d;
    logic [data_width-1:0] payload_d;
    logic                  launch, accept, dest_ok, count_en;
    logic                  unused_w;

    // Slot counter free-runs 0..rate-1 only while injection is globally enabled
    always_comb begin
        slot_d = slot_q;
        if (start_i) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end
    end

    // Build the next packet from the current LFSR state and sequence number
    always_comb begin
        if (PAT_SEL == PAT_TRANSPOSE) begin
            dx_d = x_size'(MY_Y);
            dy_d = y_size'(MY_X);
        end else begin
            dx_d = x_size'(32'(lfsr_q[7:0]) % X);
            dy_d = y_size'(32'(lfsr_q[15:8]) % Y);
        end
        payload_d        = '0;
        payload_d[31:0]  = sent_q;
        payload_d[47:32] = 16'(IDX);
        pkt_d            = {payload_d, dy_d, dx_d};
    end

    assign launch  = !valid_q && (slot_q == '0) && start_i && enable_i
                     && (sent_q < 32'(numPackets));
    assign accept  = valid_q && r_ready_i;
    assign dest_ok = (w_data_i[x_size-1:0] == x_size'(MY_X))
                     && (w_data_i[x_size+y_size-1:x_size] == y_size'(MY_Y));
    assign count_en = w_valid_i && (!DEST_CHECK || dest_ok);
    assign unused_w = ^w_data_i;

    // Injection handshake, sequence/LFSR advance and delivery counting
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
            rcv_q   <= '0;
            lfsr_q  <= 16'(IDX + 1);
        end else begin
            slot_q <= slot_d;
            if (accept) begin
                valid_q <= 1'b0;
                sent_q  <= sent_q + 32'd1;
                lfsr_q  <= lfsr_next(lfsr_q);
            end else if (launch) begin
                valid_q <= 1'b1;
                data_q  <= pkt_d;
            end
            if (count_en) begin
                rcv_q <= rcv_q + 32'd1;
            end
        end
    end

`ifdef RPE_DEST_CHECK_EN
    // Flag misrouted deliveries in simulation
    always_ff @(posedge clk) begin
        if (!rst && w_valid_i && !dest_ok) begin
            $display("ERROR: PE %0d received misrouted packet from source %0d", IDX, w_data_i[x_size+y_size+32 +: 16]);
        end
    end
`endif

    assign r_valid_o    = valid_q;
    assign r_data_o     = data_q;
    assign recv_count_o = rcv_q;
    assign fin_o        = (sent_q == 32'(numPackets)) && !valid_q;

endmodule

// File: rtl/random_pe_top.sv
// rtl/random_pe_top.sv - X*Y array of traffic-generating PEs for NoC stress (macro RPE_DEST_CHECK_EN)
module random_pe_top
    import rpe_pkg::*;
#(
    parameter int    X          = 10,
    parameter int    Y          = 10,
    parameter int    data_width = 256,
    parameter int    x_size     = $clog2(X),
    parameter int    y_size     = $clog2(Y),
    parameter int    numPackets = 1000,
    parameter int    rate       = 2,
    parameter string pat        = "RANDOM"
) (
    input  logic                  clk,
    input  logic                  rst,
    random_pe_top_if.master       noc,
    input  logic                  start,
    input  logic [X*Y-1:0]        enableSend,
    output logic                  done,
    output logic [32*X*Y-1:0]     receiveCount
);

    localparam int   N       = X * Y;
    localparam int   TW      = tw_width(x_size, y_size, data_width);
    localparam pat_e PAT_SEL = (pat == "TRANSPOSE") ? PAT_TRANSPOSE : PAT_RANDOM;

    logic [N-1:0] fin;
    logic         done_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_pe
        random_pe #(
            .X          (X),
            .Y          (Y),
            .data_width (data_width),
            .x_size     (x_size),
            .y_size     (y_size),
            .numPackets (numPackets),
            .rate       (rate),
            .PAT_SEL    (PAT_SEL),
            .IDX        (gi)
        ) u_pe (
            .clk          (clk),
            .rst          (rst),
            .start_i      (start),
            .enable_i     (enableSend[gi]),
            .r_valid_o    (noc.r_valid_pe[gi]),
            .r_data_o     (noc.r_data_pe[gi*TW +: TW]),
            .r_ready_i    (noc.r_ready_pe[gi]),
            .w_valid_i    (noc.w_valid_pe[gi]),
            .w_data_i     (noc.w_data_pe[gi*TW +: TW]),
            .recv_count_o (receiveCount[gi*32 +: 32]),
            .fin_o        (fin[gi])
        );
    end

    // Done once every enabled PE has drained its quota; disabled PEs are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= &(fin | ~enableSend);
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_random_pe_top.sv
// tb/tb_random_pe_top.sv - scoreboard bench for random_pe_top
module tb_random_pe_top;
    localparam int X = 2, Y = 2, N = 4, DW = 48, TW = 50, NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_lfsr(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [TW-1:0] m_pkt(input int src, input int seq, input logic [15:0] lf, input bit tr);
        int ix, iy;
        if (tr) begin
            ix = src / X;
            iy = src % X;
        end else begin
            ix = int'(lf[7:0]) % X;
            iy = int'(lf[15:8]) % Y;
        end
        return {16'(src), 32'(seq), 1'(iy), 1'(ix)};
    endfunction

    function automatic int m_dest(input logic [TW-1:0] p);
        return int'(p[1]) * X + int'(p[0]);
    endfunction

    function automatic int rc_sum(input logic [32*N-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i*32 +: 32]);
        return s;
    endfunction

    // ---------------- DUT A: rate 2, RANDOM, loopback stub ----------------
    logic rst_a = 1'b1, start_a = 1'b0;
    logic [N-1:0] en_a = '1, rdy_a = '1;
    logic done_a;
    logic [32*N-1:0] rc_a;
    random_pe_top_if #(.N(N), .TW(TW)) noc_a ();
    assign noc_a.r_ready_pe = rdy_a;

    random_pe_top #(.X(X), .Y(Y), .data_width(DW), .numPackets(NP), .rate(2), .pat("RANDOM")) dut_a (
        .clk(clk), .rst(rst_a), .noc(noc_a), .start(start_a), .enableSend(en_a),
        .done(done_a), .receiveCount(rc_a));

    logic [TW-1:0] stubq [N][$];
    always @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < N; i++) stubq[i].delete();
            noc_a.w_valid_pe <= '0;
            noc_a.w_data_pe  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (stubq[i].size() > 0) begin
                    noc_a.w_valid_pe[i] <= 1'b1;
                    noc_a.w_data_pe[i*TW +: TW] <= stubq[i].pop_front();
                end else begin
                    noc_a.w_valid_pe[i] <= 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (noc_a.r_valid_pe[i] && noc_a.r_ready_pe[i])
                    stubq[m_dest(noc_a.r_data_pe[i*TW +: TW])].push_back(noc_a.r_data_pe[i*TW +: TW]);
            end
        end
    end

    logic [TW-1:0] expq_a [N][$];
    int exp_rcv_a [N];
    int hs_a [N];
    int last_hs_a = 0, done_cyc_a = 0;
    logic done_prev_a = 1'b0;

    always @(negedge clk) begin
        if (!rst_a) begin
            for (int i = 0; i < N; i++) begin
                if (noc_a.r_valid_pe[i] && noc_a.r_ready_pe[i]) begin
                    hs_a[i]++;
                    last_hs_a = cyc;
                    if (expq_a[i].size() == 0) check("a_unexpected_pkt", 64'(i), 64'hFF);
                    else check($sformatf("a_pkt_pe%0d", i), 64'(noc_a.r_data_pe[i*TW +: TW]), 64'(expq_a[i].pop_front()));
                end
            end
            if (done_a && !done_prev_a) done_cyc_a = cyc;
        end
        done_prev_a = done_a;
    end

    task automatic load_expect(input logic [N-1:0] en);
        logic [15:0] lf;
        logic [TW-1:0] p;
        for (int i = 0; i < N; i++) begin
            expq_a[i].delete();
            exp_rcv_a[i] = 0;
            hs_a[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            lf = 16'(i + 1);
            if (en[i]) begin
                for (int k = 0; k < NP; k++) begin
                    p = m_pkt(i, k, lf, 1'b0);
                    expq_a[i].push_back(p);
                    exp_rcv_a[m_dest(p)]++;
                    lf = m_lfsr(lf);
                end
            end
        end
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        rst_a = 1'b1;
        start_a = 1'b0;
        for (int i = 0; i < N; i++) expq_a[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    function automatic int hs_total();
        return hs_a[0] + hs_a[1] + hs_a[2] + hs_a[3];
    endfunction

    function automatic int q_left();
        return expq_a[0].size() + expq_a[1].size() + expq_a[2].size() + expq_a[3].size();
    endfunction

    // ---------------- DUT B: rate 3 ----------------
    logic rst_b = 1'b1, start_b = 1'b0;
    logic done_b;
    logic [32*N-1:0] rc_b;
    random_pe_top_if #(.N(N), .TW(TW)) noc_b ();
    assign noc_b.r_ready_pe = '1;
    assign noc_b.w_valid_pe = '0;
    assign noc_b.w_data_pe  = '0;

    random_pe_top #(.X(X), .Y(Y), .data_width(DW), .numPackets(NP), .rate(3), .pat("RANDOM")) dut_b (
        .clk(clk), .rst(rst_b), .noc(noc_b), .start(start_b), .enableSend(4'b1111),
        .done(done_b), .receiveCount(rc_b));

    logic [TW-1:0] expq_b [$];
    int pulses_b = 0, last_b = -1;
    always @(negedge clk) begin
        if (!rst_b && noc_b.r_valid_pe[0]) begin
            pulses_b++;
            if (last_b >= 0) check("b_gap", 64'(cyc - last_b), 64'd3);
            last_b = cyc;
            if (expq_b.size() == 0) check("b_unexpected_pkt", 64'd1, 64'd0);
            else check("b_pkt_pe0", 64'(noc_b.r_data_pe[TW-1:0]), 64'(expq_b.pop_front()));
        end
    end

    // ---------------- DUT C: TRANSPOSE ----------------
    logic rst_c = 1'b1, start_c = 1'b0;
    logic done_c;
    logic [32*N-1:0] rc_c;
    random_pe_top_if #(.N(N), .TW(TW)) noc_c ();
    assign noc_c.r_ready_pe = '1;
    assign noc_c.w_valid_pe = '0;
    assign noc_c.w_data_pe  = '0;

    random_pe_top #(.X(X), .Y(Y), .data_width(DW), .numPackets(NP), .rate(2), .pat("TRANSPOSE")) dut_c (
        .clk(clk), .rst(rst_c), .noc(noc_c), .start(start_c), .enableSend(4'b1111),
        .done(done_c), .receiveCount(rc_c));

    logic [TW-1:0] expq_c [$];
    int pulses_c = 0;
    always @(negedge clk) begin
        if (!rst_c && noc_c.r_valid_pe[1]) begin
            pulses_c++;
            check("c_dest_x", 64'(noc_c.r_data_pe[TW + 0]), 64'd0);
            check("c_dest_y", 64'(noc_c.r_data_pe[TW + 1]), 64'd1);
            if (expq_c.size() == 0) check("c_unexpected_pkt", 64'd1, 64'd0);
            else check("c_pkt_pe1", 64'(noc_c.r_data_pe[TW +: TW]), 64'(expq_c.pop_front()));
        end
    end

    task automatic wait_done(input int which, input string tag);
        int t;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if ((which == 0 && done_a) || (which == 1 && done_b) || (which == 2 && done_c)) break;
        end
        check({tag, "_done_seen"}, 64'(t < 300), 64'd1);
    endtask

    logic [TW-1:0] d0;
    bit got;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(noc_a.r_valid_pe), 64'd0);
        check("rst_data", 64'(|noc_a.r_data_pe), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_rcv", 64'(|rc_a), 64'd0);

        // Full run, all PEs, loopback
        load_expect(4'b1111);
        rst_a = 1'b0;
        start_a = 1'b1;
        wait_done(0, "full");
        repeat (12) @(negedge clk);
        check("full_hs_total", 64'(hs_total()), 64'd16);
        check("full_q_left", 64'(q_left()), 64'd0);
        check("full_done", 64'(done_a), 64'd1);
        check("full_done_latency", 64'(done_cyc_a - last_hs_a), 64'd2);
        check("full_rcv_sum", 64'(rc_sum(rc_a)), 64'd16);
        for (int i = 0; i < N; i++)
            check($sformatf("full_rcv_pe%0d", i), 64'(rc_a[i*32 +: 32]), 64'(exp_rcv_a[i]));

        // Backpressure on PE0
        reset_a();
        en_a = 4'b0001;
        rdy_a = 4'b1110;
        load_expect(4'b0001);
        start_a = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (noc_a.r_valid_pe[0]) begin
                got = 1'b1;
                break;
            end
        end
        check("hold_valid_seen", 64'(got), 64'd1);
        d0 = noc_a.r_data_pe[TW-1:0];
        for (int t = 0; t < 5; t++) begin
            if (t > 0) @(negedge clk);
            check("hold_valid", 64'(noc_a.r_valid_pe[0]), 64'd1);
            check("hold_data", 64'(noc_a.r_data_pe[TW-1:0]), 64'(d0));
            check("hold_sent", 64'(hs_a[0]), 64'd0);
        end
        @(posedge clk);
        #1 rdy_a = '1;
        @(negedge clk);
        @(negedge clk);
        check("hold_one_xfer", 64'(hs_a[0]), 64'd1);
        wait_done(0, "hold");
        check("hold_hs_total", 64'(hs_a[0]), 64'd4);

        // Partial enable 0101
        reset_a();
        en_a = 4'b0101;
        load_expect(4'b0101);
        start_a = 1'b1;
        wait_done(0, "part");
        repeat (12) @(negedge clk);
        check("part_hs_total", 64'(hs_total()), 64'd8);
        check("part_hs_pe1", 64'(hs_a[1]), 64'd0);
        check("part_hs_pe3", 64'(hs_a[3]), 64'd0);
        check("part_rcv_sum", 64'(rc_sum(rc_a)), 64'd8);
        check("part_q_left", 64'(q_left()), 64'd0);

        // Mid-run abort and identical rerun
        reset_a();
        en_a = 4'b1111;
        load_expect(4'b1111);
        start_a = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_a = 1'b1;
        for (int i = 0; i < N; i++) expq_a[i].delete();
        @(posedge clk);
        #1;
        check("abort_valid", 64'(noc_a.r_valid_pe), 64'd0);
        check("abort_data", 64'(|noc_a.r_data_pe), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_rcv", 64'(|rc_a), 64'd0);
        load_expect(4'b1111);
        rst_a = 1'b0;
        wait_done(0, "rerun");
        repeat (12) @(negedge clk);
        check("rerun_hs_total", 64'(hs_total()), 64'd16);
        check("rerun_q_left", 64'(q_left()), 64'd0);
        check("rerun_rcv_sum", 64'(rc_sum(rc_a)), 64'd16);

        // Rate 3
        begin
            logic [15:0] lf;
            lf = 16'd1;
            for (int k = 0; k < NP; k++) begin
                expq_b.push_back(m_pkt(0, k, lf, 1'b0));
                lf = m_lfsr(lf);
            end
        end
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        start_b = 1'b1;
        wait_done(1, "rate3");
        repeat (4) @(negedge clk);
        check("rate3_pulses", 64'(pulses_b), 64'd4);
        check("rate3_q_left", 64'(expq_b.size()), 64'd0);
        check("rate3_rcv", 64'(|rc_b), 64'd0);

        // Transpose
        for (int k = 0; k < NP; k++) expq_c.push_back(m_pkt(1, k, 16'd0, 1'b1));
        @(posedge clk);
        #1;
        rst_c = 1'b0;
        start_c = 1'b1;
        wait_done(2, "transpose");
        repeat (4) @(negedge clk);
        check("transpose_pulses", 64'(pulses_c), 64'd4);
        check("transpose_q_left", 64'(expq_c.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/random_pe_top.md
RANDOM_PE_TOP -- requirements
Module: random_pe_top

Interface
REQ-001 SHALL have parameter X, default 10, meaning mesh columns.
REQ-002 SHALL have parameter Y, default 10, meaning mesh rows.
REQ-003 SHALL have parameter data_width, default 256, meaning payload bits (minimum 48).
REQ-004 SHALL have parameters x_size and y_size, defaults $clog2(X) and $clog2(Y), meaning destination coordinate widths; TW = x_size+y_size+data_width.
REQ-005 SHALL have parameter numPackets, default 1000, meaning packets injected per enabled PE.
REQ-006 SHALL have parameter rate, default 2, meaning injection slot period in cycles (at least 1).
REQ-007 SHALL have parameter pat, default "RANDOM", meaning destination pattern ("RANDOM" or "TRANSPOSE").
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have ports r_valid_pe (output, X*Y bits) and r_data_pe (output, TW*X*Y bits): injection into the NoC, PE i in slice i.
REQ-011 SHALL have port r_ready_pe, input, X*Y bits: NoC accepts PE i's packet.
REQ-012 SHALL have ports w_valid_pe (input, X*Y bits) and w_data_pe (input, TW*X*Y bits): delivery from the NoC; no backpressure exists.
REQ-013 SHALL have port start, input, 1 bit: global injection enable.
REQ-014 SHALL have port enableSend, input, X*Y bits: per-PE injection enable.
REQ-015 SHALL have port done, output, 1 bit: all enabled PEs have finished injecting.
REQ-016 SHALL have port receiveCount, output, 32*X*Y bits: packets received per PE.

Function
REQ-017 SHALL assign PE i the coordinates x=i%X and y=i/X.
REQ-018 SHALL pack each packet as: [x_size-1:0] dest x, then y_size bits dest y, then payload; payload[31:0] is the sequence number (0..numPackets-1), payload[47:32] is the source index i, and the remaining bits are zero.
REQ-019 SHALL, under "RANDOM", give each PE a 16-bit Galois LFSR (taps 0xB400, seed i+1), advanced once per accepted packet; dest x = lfsr[7:0]%X, dest y = lfsr[15:8]%Y; self-destination is allowed.
REQ-020 SHALL, under "TRANSPOSE", send to dest (x=y_src, y=x_src); this pattern requires X==Y.
REQ-021 SHALL give each PE a slot counter cycling 0..rate-1 while start is high.
REQ-022 SHALL let a PE raise r_valid_pe only in a cycle where its slot counter is 0, start and enableSend[i] are high, no packet is pending, and sent<numPackets.
REQ-023 SHALL hold valid and data stable until r_valid&r_ready; the transfer completes in that cycle, sent increments, and the next packet waits for a later slot-0 cycle.
REQ-024 SHALL NOT retract a pending packet when start or enableSend drops.
REQ-025 SHALL increment receiveCount[i] by 1 in every cycle where w_valid_pe[i] is high; the counter wraps at 2^32.
REQ-026 SHALL drive done high when every PE with enableSend[i]=1 has sent==numPackets and has no pending packet; done is registered (one cycle after the last handshake).

Reset
REQ-027 SHALL, while rst is high, clear r_valid_pe, r_data_pe, done, receiveCount, the sent counters and the slot counters, and reload the LFSR seeds.
REQ-028 SHALL treat a reset in the middle of a run as a full abort: pending packets are dropped and no state is retained.

Configuration
REQ-029 SHALL, when macro RPE_DEST_CHECK_EN is defined, count a delivered packet only if its dest fields equal the receiving PE's coordinates; a mismatch is not counted and prints a simulation $display error naming the PE and source.
REQ-030 SHALL, when RPE_DEST_CHECK_EN is undefined, count every delivery unconditionally.

Structure
REQ-031 SHALL place the pattern encoding, the LFSR taps constant and the TW width function in shared package rpe_pkg.
REQ-032 SHALL implement one sub-module, random_pe, instantiated X*Y times by generate, each with its own index parameter.

Verification
REQ-033 SHALL cover: X=2, Y=2, numPackets=4, rate=2, NoC stub always ready looping r_* back to the destination's w_* one cycle later -> 16 injections, done=1, receiveCount sum=16.
REQ-034 SHALL cover: rate=3 with ready always high -> PE0 valid pulses exactly every 3rd cycle, 4 pulses total.
REQ-035 SHALL cover: r_ready_pe[0] held low for 5 cycles -> PE0 valid and data stable for 5 cycles, sent unchanged; one transfer when ready rises.
REQ-036 SHALL cover: enableSend=4'b0101 -> only PEs 0 and 2 inject (8 packets total), and done asserts.
REQ-037 SHALL cover: "TRANSPOSE" with X=Y=2 -> PE1 (x1,y0) sends only to dest (x0,y1), with sequence numbers 0..3.
REQ-038 SHALL cover: rst asserted mid-run for 1 cycle -> all outputs 0; after release, the rerun produces an identical packet sequence.
